// File: rtl/gshare_btb_predictor_pkg.sv
// Shared widths, table entry layouts, bundle types and FSM states for the gshare/BTB predictor.
package gshare_btb_predictor_pkg;

  localparam int unsigned DBITS        = 32;
  localparam int unsigned BHR_BITS     = 8;
  localparam int unsigned BTB_IDX_BITS = 4;
  localparam int unsigned TAG_BITS     = DBITS - BTB_IDX_BITS - 2;
  localparam int unsigned PHT_ENTRIES  = 2 ** BHR_BITS;
  localparam int unsigned BTB_ENTRIES  = 2 ** BTB_IDX_BITS;

  // Weakly not-taken.
  localparam logic [1:0] PHT_INIT = 2'b01;

  typedef enum logic [0:0] {
    StInit,
    StRun
  } state_e;

  typedef struct packed {
    logic                valid;
    logic                is_cond;
    logic [TAG_BITS-1:0] tag;
    logic [DBITS-1:0]    target;
  } btb_entry_t;

  typedef struct packed {
    logic                    taken;
    logic [DBITS-1:0]        target;
    logic [BHR_BITS-1:0]     bhr;
    logic [BHR_BITS-1:0]     pht_idx;
    logic [1:0]              pht_ctr;
    logic [BTB_IDX_BITS-1:0] btb_idx;
  } pred_to_fe_t;

  typedef struct packed {
    logic                valid;
    logic                is_cond;
    logic                taken;
    logic [DBITS-1:0]    pc;
    logic [DBITS-1:0]    target;
    logic [BHR_BITS-1:0] pht_idx;
    logic [1:0]          pht_ctr;
  } agex_to_pred_t;

endpackage

// File: rtl/gshare_btb_predictor_if.sv
// Fetch lookup / AGEX training bundle seen by the predictor; master is the pipeline side.
interface gshare_btb_predictor_if;
  import gshare_btb_predictor_pkg::*;

  logic [DBITS-1:0]        pc_fe;
  logic                    pred_taken;
  logic [DBITS-1:0]        pred_target;
  logic [BHR_BITS-1:0]     pred_bhr;
  logic [BHR_BITS-1:0]     pred_pht_idx;
  logic [1:0]              pred_pht_ctr;
  logic [BTB_IDX_BITS-1:0] pred_btb_idx;
  logic                    upd_valid;
  logic                    upd_is_cond;
  logic                    upd_taken;
  logic [DBITS-1:0]        upd_pc;
  logic [DBITS-1:0]        upd_target;
  logic [BHR_BITS-1:0]     upd_pht_idx;
  logic [1:0]              upd_pht_ctr;
  logic                    init_busy;

  modport master (
    output pc_fe, upd_valid, upd_is_cond, upd_taken, upd_pc, upd_target, upd_pht_idx,
           upd_pht_ctr,
    input  pred_taken, pred_target, pred_bhr, pred_pht_idx, pred_pht_ctr, pred_btb_idx,
           init_busy
  );

  modport slave (
    input  pc_fe, upd_valid, upd_is_cond, upd_taken, upd_pc, upd_target, upd_pht_idx,
           upd_pht_ctr,
    output pred_taken, pred_target, pred_bhr, pred_pht_idx, pred_pht_ctr, pred_btb_idx,
           init_busy
  );

endinterface

// File: rtl/gshare_btb_predictor_sat_counter2.sv
// 2-bit saturating up/down counter step, purely combinational.
module sat_counter2 (
  input  logic [1:0] ctr_i,
  input  logic       inc_i,
  output logic [1:0] ctr_o
);

  always_comb begin
    ctr_o = ctr_i;
    if (inc_i) begin
      if (ctr_i != 2'b11) ctr_o = ctr_i + 2'b01;
    end else begin
      if (ctr_i != 2'b00) ctr_o = ctr_i - 2'b01;
    end
  end

endmodule

// File: rtl/gshare_btb_predictor.sv
// Gshare direction predictor with a direct-mapped BTB: zero-latency lookup for fetch,
// trained by resolved branches from AGEX, tables cleared by an init sweep after reset.
module gshare_btb_predictor
  import gshare_btb_predictor_pkg::*;
(
  input logic                         clk,
  input logic                         reset,
  gshare_btb_predictor_if.slave       bp
);

  state_e              state_q, state_d;
  logic [BHR_BITS-1:0] cnt_q, cnt_d;
  logic [BHR_BITS-1:0] bhr_q, bhr_d;

  logic [1:0] pht_q [PHT_ENTRIES];
  btb_entry_t btb_q [BTB_ENTRIES];

  logic                    pht_we;
  logic [BHR_BITS-1:0]     pht_waddr;
  logic [1:0]              pht_wdata;
  logic                    btb_we;
  logic [BTB_IDX_BITS-1:0] btb_waddr;
  btb_entry_t              btb_wdata;

  agex_to_pred_t upd;
  pred_to_fe_t   pred;
  logic [1:0]    trained_ctr;
  logic          run;

  logic [BHR_BITS-1:0]     lk_pht_idx;
  logic [BTB_IDX_BITS-1:0] lk_btb_idx;
  logic [1:0]              lk_ctr;
  btb_entry_t              lk_entry;
  logic                    lk_hit;
  logic                    lk_taken;

  assign upd = '{
    valid:   bp.upd_valid,
    is_cond: bp.upd_is_cond,
    taken:   bp.upd_taken,
    pc:      bp.upd_pc,
    target:  bp.upd_target,
    pht_idx: bp.upd_pht_idx,
    pht_ctr: bp.upd_pht_ctr
  };

  assign run = (state_q == StRun);

  // Lookup reads the arrays directly, so a same-cycle update is not visible until next cycle.
  always_comb begin
    lk_pht_idx = bp.pc_fe[BHR_BITS+1:2] ^ bhr_q;
    lk_btb_idx = bp.pc_fe[BTB_IDX_BITS+1:2];
    lk_ctr     = pht_q[lk_pht_idx];
    lk_entry   = btb_q[lk_btb_idx];
    lk_hit     = lk_entry.valid && (lk_entry.tag == bp.pc_fe[DBITS-1:BTB_IDX_BITS+2]);
    lk_taken   = lk_hit && (!lk_entry.is_cond || lk_ctr[1]);
  end

  always_comb begin
    pred = '0;
    if (run) begin
      pred.taken   = lk_taken;
      pred.target  = lk_taken ? lk_entry.target : '0;
      pred.bhr     = bhr_q;
      pred.pht_idx = lk_pht_idx;
      pred.pht_ctr = lk_ctr;
      pred.btb_idx = lk_btb_idx;
    end
  end

  assign bp.pred_taken   = pred.taken;
  assign bp.pred_target  = pred.target;
  assign bp.pred_bhr     = pred.bhr;
  assign bp.pred_pht_idx = pred.pht_idx;
  assign bp.pred_pht_ctr = pred.pht_ctr;
  assign bp.pred_btb_idx = pred.btb_idx;
  assign bp.init_busy    = !run;

  // The carried counter is the training base, not a fresh read of the PHT.
  sat_counter2 u_sat_counter2 (
    .ctr_i (upd.pht_ctr),
    .inc_i (upd.taken),
    .ctr_o (trained_ctr)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bhr_d     = bhr_q;
    pht_we    = 1'b0;
    pht_waddr = cnt_q;
    pht_wdata = PHT_INIT;
    btb_we    = 1'b0;
    btb_waddr = cnt_q[BTB_IDX_BITS-1:0];
    btb_wdata = '0;
    unique case (state_q)
      StInit: begin
        pht_we = 1'b1;
        btb_we = 1'b1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == '1) state_d = StRun;
      end
      StRun: begin
        if (upd.valid && upd.is_cond) begin
          pht_we    = 1'b1;
          pht_waddr = upd.pht_idx;
          pht_wdata = trained_ctr;
          bhr_d     = {bhr_q[BHR_BITS-2:0], upd.taken};
        end
        if (upd.valid && upd.taken) begin
          btb_we    = 1'b1;
          btb_waddr = upd.pc[BTB_IDX_BITS+1:2];
          btb_wdata = '{
            valid:   1'b1,
            is_cond: upd.is_cond,
            tag:     upd.pc[DBITS-1:BTB_IDX_BITS+2],
            target:  upd.target
          };
        end
      end
      default: state_d = StInit;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StInit;
      cnt_q   <= '0;
      bhr_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bhr_q   <= bhr_d;
    end
  end

  // Tables have no reset; the init sweep clears them.
  always_ff @(posedge clk) begin
    if (pht_we) pht_q[pht_waddr] <= pht_wdata;
    if (btb_we) btb_q[btb_waddr] <= btb_wdata;
  end

  logic unused_pc_bits;
  assign unused_pc_bits = ^{bp.pc_fe[1:0], bp.upd_pc[1:0]};

endmodule
